instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and loader for the pipelined RSA CPU. It takes decoded instruction fields from a valid/ready stream, packs each one into a 32-bit instruction word, and writes the word into instruction memory at sequential addresses. Its field encoding is the exact inverse of the CPU's main decoder and ALU decoder. It sits between the host/testbench program source and the instruction-memory write port, and is used to boot-load programs before the CPU runs.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; reloads the address counter to `BASE_ADDR`, clears `err` and `count`, and enters ACCEPT.
- `finish` in 1: pulse; ends the load and enters DONE.
- `in_valid` in 1 / `in_ready` out 1: instruction-field handshake.
- `in_kind` in 3: 0 DP_REG, 1 DP_IMM, 2 CMP_REG, 3 CMP_IMM, 4 LDR, 5 STR, 6 B; 7 is illegal.
- `in_alu` in 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV; 101–111 are illegal.
- `in_cond` in 4: condition field.
- `in_rd`, `in_rn`, `in_rm` in 4 each: register numbers.
- `in_imm` in 12: immediate value or memory offset.
- `in_target` in ADDR_W: absolute branch target word address.
- `imem_we` out 1, `imem_addr` out ADDR_W, `imem_wdata` out 32, `imem_ack` in 1: memory write port.
- `busy` out 1, `full` out 1, `err` out 1 (sticky), `count` out ADDR_W+1.

## Operation
- States:
  - IDLE.
  - ACCEPT: `in_ready`=1.
  - WRITE: `imem_we`=1.
  - HALT: only when `INSTR_ENC_HALT_EN` is defined.
  - DONE.
  - FULL.
- Transitions:
  - IDLE, DONE or FULL, on `start` → ACCEPT.
  - ACCEPT, on a legal handshake → WRITE. The word is registered at this point.
  - WRITE, on `imem_ack` → increment address and `count`. If the address written was 2^ADDR_W−1, go to FULL; otherwise go to ACCEPT.
  - ACCEPT, on `finish` → DONE (or HALT).
  - `start` in any state aborts the current operation and restarts at ACCEPT.
- Word layout: cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], Src2[11:0].
- DP: op=00, funct={I, cmd, S=0}.
  - cmd mapping from `in_alu`: ADD→0100, SUB→0010, AND→0000, ORR→1100, MOV→1101.
  - MOV forces Rn=0.
  - DP_REG: Src2={8'h00, rm}.
  - DP_IMM: Src2={4'h0, imm[7:0]}. If imm[11:8]≠0, the instruction is illegal.
- CMP: op=00, funct={I, 1010, 1}, Rd=0. `in_alu` is ignored. Src2 is formed as for DP.
- LDR: op=01, funct=011001, Src2=imm[11:0].
- STR: op=01, funct=011000, Src2=imm[11:0].
- B: op=10, bits[25:24]=10, imm24 = sign-extend(`in_target`) − (`imem_addr`+2), computed mod 2^24.
- Illegal input:
  - The handshake still completes.
  - No word is written and `count` is unchanged.
  - `err` is set to 1 and stays in ACCEPT.
- `busy` = state ∉ {IDLE, DONE}.
- `full` = (state==FULL).

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `busy`=0, `full`=0, `err`=0, `count`=0.
- A handshake on cycle N gives `imem_we`=1 with stable `imem_addr` and `imem_wdata` from cycle N+1 until the cycle `imem_ack`=1, inclusive.
- `in_ready` returns the cycle after the ack. Maximum throughput is 1 word per 2 cycles.
- `imem_ack` while `imem_we`=0 is ignored.
- `finish` and `in_valid` in the same ACCEPT cycle: `finish` wins and the input is not consumed.
- `start` and `finish` together: `start` wins.
- Asynchronous reset during WRITE drops `imem_we` immediately.

## Configuration
- `INSTR_ENC_HALT_EN` defined:
  - `finish` enters HALT, which writes the terminator 0xEAFFFFFE (B to self) at the current address, then goes to DONE after the ack.
  - In FULL, `finish` goes directly to DONE with no write.
- `INSTR_ENC_HALT_EN` undefined: `finish` goes straight to DONE and the HALT state is absent.

## Structure
- Package `instr_enc_pkg` holds:
  - the kind enum;
  - the ALU codes;
  - the cmd constants (CMD_ADD/SUB/AND/ORR/CMP/MOV);
  - OP_DP/OP_MEM/OP_BR;
  - FUNCT_LDR/FUNCT_STR;
  - COND_AL=4'hE;
  - HALT_WORD.
- Sub-module `instr_word_pack`: combinational fields+address → {word, illegal}. The FSM, counter and handshake live in the top.

## Test plan
- Reset low → all outputs at their reset values. `start` → `in_ready`=1, `imem_addr`=0.
- DP_REG ADD, cond E, rd=1, rn=2, rm=3 → `imem_wdata`=0xE0821003 at addr 0, `count`=1.
- CMP_IMM rn=4, imm=5 → 0xE3540005. LDR rd=0, rn=1, imm=8 → 0xE5910008. STR rd=2, rn=3, imm=4 → 0xE5832004.
- At addr 5, B target=0 → 0xEAFFFFF9. With `imem_ack` held low 3 cycles → `imem_we`, address and data held stable and `in_ready`=0 throughout.
- alu=101, or DP_IMM with imm=0x105 → `err`=1, no write, `count` unchanged. The next legal input is still written.
- ADDR_W=2: 4 writes → `full`=1, `in_ready`=0. With HALT_EN, in ACCEPT `finish` → 0xEAFFFFFE written, then DONE with `busy`=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared encodings for the instruction encoder/loader. Every constant here is
// the inverse of the CPU main decoder and ALU decoder:
//   kind_e       - instruction class presented on the input stream
//   ALU_*        - in_alu codes accepted for data-processing instructions
//   CMD_*        - 4-bit cmd field placed in funct[4:1] of DP/CMP words
//   OP_*         - 2-bit op field, word bits [27:26]
//   FUNCT_LDR/STR- full 6-bit funct for memory instructions
//   COND_AL      - "always" condition code
//   HALT_WORD    - branch-to-self terminator written by the optional HALT state
// -----------------------------------------------------------------------------
package instr_enc_pkg;

  typedef enum logic [2:0] {
    KIND_DP_REG  = 3'd0,
    KIND_DP_IMM  = 3'd1,
    KIND_CMP_REG = 3'd2,
    KIND_CMP_IMM = 3'd3,
    KIND_LDR     = 3'd4,
    KIND_STR     = 3'd5,
    KIND_B       = 3'd6,
    KIND_ILLEGAL = 3'd7
  } kind_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [5:0] FUNCT_LDR = 6'b011001;
  localparam logic [5:0] FUNCT_STR = 6'b011000;

  localparam logic [3:0]  COND_AL   = 4'hE;
  localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;

  typedef struct packed {
    logic       ok;
    logic [3:0] cmd;
  } cmd_t;

  // Maps an in_alu code to its decoder cmd; ok=0 flags the reserved codes.
  function automatic cmd_t alu_to_cmd(input logic [2:0] alu);
    cmd_t r;
    r.ok  = 1'b1;
    r.cmd = CMD_AND;
    case (alu)
      ALU_ADD: r.cmd = CMD_ADD;
      ALU_SUB: r.cmd = CMD_SUB;
      ALU_AND: r.cmd = CMD_AND;
      ALU_ORR: r.cmd = CMD_ORR;
      ALU_MOV: r.cmd = CMD_MOV;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// -----------------------------------------------------------------------------
// instr_word_pack
// Purely combinational: packs one set of decoded fields into a 32-bit word
// laid out as cond[31:28] op[27:26] funct[25:20] Rn[19:16] Rd[15:12] Src2[11:0]
// and flags combinations the decoder cannot represent.
// Ports:
//   kind, alu, cond, rd, rn, rm, imm, target - decoded instruction fields
//   addr    - word address the result will be written to (branch base)
//   word    - packed instruction (don't-care when illegal)
//   illegal - kind 7, reserved ALU code on DP, or immediate wider than 8 bits
// -----------------------------------------------------------------------------
module instr_word_pack
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [2:0]        kind,
  input  logic [2:0]        alu,
  input  logic [3:0]        cond,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [11:0]       imm,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word,
  output logic              illegal
);

  cmd_t        dp;
  logic        is_imm;
  logic        imm_wide;
  logic [11:0] src2;
  logic [23:0] tgt_ext;
  logic [23:0] pc_plus2;
  logic [23:0] br_off;

  assign dp       = alu_to_cmd(alu);
  assign is_imm   = (kind == KIND_DP_IMM) || (kind == KIND_CMP_IMM);
  // Only an 8-bit immediate fits the DP/CMP Src2 form; the rotate nibble is 0.
  assign imm_wide = (imm[11:8] != 4'h0);
  assign src2     = is_imm ? {4'h0, imm[7:0]} : {8'h00, rm};

  // Branch offset is relative to the word two past the one being written,
  // wrapping modulo 2^24. The target is treated as a signed word address.
  assign tgt_ext  = {{(24-ADDR_W){target[ADDR_W-1]}}, target};
  assign pc_plus2 = 24'(addr) + 24'd2;
  assign br_off   = tgt_ext - pc_plus2;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_DP_REG, KIND_DP_IMM: begin
        illegal = !dp.ok || (is_imm && imm_wide);
        word    = {cond, OP_DP, is_imm, dp.cmd, 1'b0,
                   (alu == ALU_MOV) ? 4'h0 : rn, rd, src2};
      end
      KIND_CMP_REG, KIND_CMP_IMM: begin
        illegal = is_imm && imm_wide;
        word    = {cond, OP_DP, is_imm, CMD_CMP, 1'b1, rn, 4'h0, src2};
      end
      KIND_LDR: word = {cond, OP_MEM, FUNCT_LDR, rn, rd, imm};
      KIND_STR: word = {cond, OP_MEM, FUNCT_STR, rn, rd, imm};
      KIND_B:   word = {cond, OP_BR, 2'b10, br_off};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Boot-loader front end: accepts decoded instruction fields on a valid/ready
// stream, packs each into a 32-bit word and writes it to instruction memory at
// sequential word addresses starting from BASE_ADDR.
// Optional feature: define INSTR_ENC_HALT_EN to have `finish` write a
// branch-to-self terminator (HALT state) before entering DONE.
// Ports:
//   clk, reset (async, active-low)
//   start, finish         - load control pulses (start has priority)
//   in_valid/in_ready     - field handshake; in_kind/alu/cond/rd/rn/rm/imm/target
//   imem_we/addr/wdata    - memory write request, held until imem_ack
//   busy, full, err       - status (err is sticky until start)
//   count                 - words written since start
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

`ifdef INSTR_ENC_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_HALT, S_DONE, S_FULL} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_FULL} state_e;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e      state, state_nx;
  logic [31:0] word;
  logic        illegal;
  logic        restart;    // start pulse: clear counters, re-arm
  logic        take_word;  // legal handshake: latch packed word
  logic        take_bad;   // illegal handshake: consume and flag
  logic        commit;     // write acknowledged: advance address
  logic        take_halt;  // entering HALT: latch terminator

  instr_word_pack #(.ADDR_W(ADDR_W)) u_pack (
    .kind    (in_kind),
    .alu     (in_alu),
    .cond    (in_cond),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .imm     (in_imm),
    .target  (in_target),
    .addr    (imem_addr),
    .word    (word),
    .illegal (illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    restart   = 1'b0;
    take_word = 1'b0;
    take_bad  = 1'b0;
    commit    = 1'b0;
    take_halt = 1'b0;
    if (start) begin
      restart  = 1'b1;
      state_nx = S_ACCEPT;
    end else begin
      case (state)
        S_ACCEPT: begin
          // finish outranks a simultaneous in_valid; the input stays pending.
          if (finish) begin
`ifdef INSTR_ENC_HALT_EN
            take_halt = 1'b1;
            state_nx  = S_HALT;
`else
            state_nx  = S_DONE;
`endif
          end else if (in_valid) begin
            if (illegal) begin
              take_bad = 1'b1;
            end else begin
              take_word = 1'b1;
              state_nx  = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (imem_ack) begin
            commit   = 1'b1;
            state_nx = (imem_addr == '1) ? S_FULL : S_ACCEPT;
          end
        end
`ifdef INSTR_ENC_HALT_EN
        S_HALT: begin
          if (imem_ack) begin
            commit   = 1'b1;
            state_nx = S_DONE;
          end
        end
`endif
        S_FULL: if (finish) state_nx = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      if (restart) begin
        imem_addr <= BASE;
        count     <= '0;
        err       <= 1'b0;
      end else begin
        if (commit) begin
          imem_addr <= imem_addr + ADDR_W'(1);
          count     <= count + (ADDR_W+1)'(1);
        end
        if (take_bad) err <= 1'b1;
      end
      if (take_word)      imem_wdata <= word;
      else if (take_halt) imem_wdata <= HALT_WORD;
    end
  end

  // Decoded from state so an asynchronous reset drops the write strobe at once.
  assign in_ready = (state == S_ACCEPT);
`ifdef INSTR_ENC_HALT_EN
  assign imem_we  = (state == S_WRITE) || (state == S_HALT);
`else
  assign imem_we  = (state == S_WRITE);
`endif
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign full     = (state == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder (ADDR_W=6, BASE_ADDR=0). Expected
// writes are queued when a field set is handed over and compared by a memory
// responder when the DUT presents the write. Status outputs are checked
// directly against bench-tracked values.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [2:0]        in_alu = '0;
  logic [3:0]        in_cond = '0;
  logic [3:0]        in_rd = '0;
  logic [3:0]        in_rn = '0;
  logic [3:0]        in_rm = '0;
  logic [11:0]       in_imm = '0;
  logic [ADDR_W-1:0] in_target = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack = 1'b0;
  logic              busy;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   count;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_alu     (in_alu),
    .in_cond    (in_cond),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ack   (imem_ack),
    .busy       (busy),
    .full       (full),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  int                n_vec = 0;
  int                n_bad = 0;
  int                ack_delay = 0;
  bit                spur_ack = 1'b0;
  int                rsp_wait = 0;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0]       h_data;
  wr_t               exp_wr;
  logic [ADDR_W-1:0] exp_addr = '0;
  int                exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: decides imem_ack for the coming edge at each falling edge.
  // A write is compared at the moment it is about to be acknowledged.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        check("ready_low_in_write", 32'(in_ready), 32'd0);
        if (rsp_wait == 0) begin
          h_addr = imem_addr;
          h_data = imem_wdata;
        end else begin
          check("addr_stable", 32'(imem_addr), 32'(h_addr));
          check("data_stable", imem_wdata, h_data);
        end
        if (rsp_wait >= ack_delay) begin
          check("write_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_wr = sb.pop_front();
            check("wr_addr", 32'(imem_addr), 32'(exp_wr.addr));
            check("wr_data", imem_wdata, exp_wr.data);
          end
          imem_ack = 1'b1;
          rsp_wait = 0;
        end else begin
          imem_ack = 1'b0;
          rsp_wait++;
        end
      end else begin
        imem_ack = spur_ack;
        rsp_wait = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr  = '0;
    exp_count = 0;
  endtask

  // Presents one field set and holds it until the DUT is ready to take it.
  task automatic send(input logic [2:0] kind, input logic [2:0] alu,
                      input logic [3:0] cond, input logic [3:0] rd,
                      input logic [3:0] rn, input logic [3:0] rm,
                      input logic [11:0] imm, input logic [ADDR_W-1:0] target,
                      input bit legal, input logic [31:0] word);
    int n = 0;
    @(negedge clk);
    in_kind = kind; in_alu = alu; in_cond = cond;
    in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_target = target;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else if (legal) begin
      sb.push_back('{addr: exp_addr, data: word});
      exp_addr  = exp_addr + 1'b1;
      exp_count++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || imem_we === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state.
    cycles(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    pulse_start();
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_addr", 32'(imem_addr), 32'd0);
    check("start_busy", 32'(busy), 32'd1);

    // Main encodings at sequential addresses.
    send(KIND_DP_REG, ALU_ADD, 4'hE, 4'd1, 4'd2, 4'd3, 12'h000, '0, 1'b1, 32'hE082_1003);
    drain();
    check("count_after_1", 32'(count), 32'd1);
    send(KIND_CMP_IMM, ALU_ADD, 4'hE, 4'd0, 4'd4, 4'd0, 12'h005, '0, 1'b1, 32'hE354_0005);
    send(KIND_LDR,     ALU_ADD, 4'hE, 4'd0, 4'd1, 4'd0, 12'h008, '0, 1'b1, 32'hE591_0008);
    send(KIND_STR,     ALU_ADD, 4'hE, 4'd2, 4'd3, 4'd0, 12'h004, '0, 1'b1, 32'hE583_2004);
    send(KIND_DP_REG,  ALU_MOV, 4'hE, 4'd7, 4'd9, 4'hA, 12'h000, '0, 1'b1, 32'hE1A0_700A);
    drain();
    check("count_after_5", 32'(count), 32'd5);
    check("addr_after_5", 32'(imem_addr), 32'd5);

    // Branches, the first one against a memory that stalls for 3 cycles.
    ack_delay = 3;
    send(KIND_B, ALU_ADD, 4'hE, 4'd0, 4'd0, 4'd0, 12'h000, 6'd0, 1'b1, 32'hEAFF_FFF9);
    drain();
    ack_delay = 0;
    send(KIND_B, ALU_ADD, 4'hE, 4'd0, 4'd0, 4'd0, 12'h000, 6'd20, 1'b1, 32'hEA00_000C);
    send(KIND_B, ALU_ADD, 4'hE, 4'd0, 4'd0, 4'd0, 12'h000, 6'd62, 1'b1, 32'hEAFF_FFF5);
    drain();
    check("count_after_8", 32'(count), 32'(exp_count));

    // Illegal inputs: consumed, flagged, nothing written.
    send(KIND_DP_REG, 3'b101, 4'hE, 4'd1, 4'd2, 4'd3, 12'h000, '0, 1'b0, 32'h0);
    cycles(1);
    check("err_alu", 32'(err), 32'd1);
    check("ready_after_illegal", 32'(in_ready), 32'd1);
    send(KIND_DP_IMM, ALU_ADD, 4'hE, 4'd1, 4'd2, 4'd0, 12'h105, '0, 1'b0, 32'h0);
    send(3'd7, ALU_ADD, 4'hE, 4'd1, 4'd2, 4'd0, 12'h000, '0, 1'b0, 32'h0);
    cycles(2);
    check("count_illegal", 32'(count), 32'd8);
    check("addr_illegal", 32'(imem_addr), 32'd8);

    // Legal inputs still land after an error; err stays set.
    send(KIND_DP_REG,  ALU_ORR, 4'h1, 4'd1, 4'd2, 4'd3, 12'h000, '0, 1'b1, 32'h1182_1003);
    send(KIND_DP_IMM,  ALU_SUB, 4'h0, 4'd5, 4'd6, 4'd0, 12'h0FF, '0, 1'b1, 32'h0246_50FF);
    send(KIND_DP_IMM,  ALU_AND, 4'hE, 4'd3, 4'd4, 4'd0, 12'h080, '0, 1'b1, 32'hE204_3080);
    send(KIND_CMP_REG, 3'b111,  4'h0, 4'd9, 4'd4, 4'd5, 12'h000, '0, 1'b1, 32'h0154_0005);
    drain();
    check("count_after_12", 32'(count), 32'd12);
    check("err_sticky", 32'(err), 32'd1);

    // Acknowledge with no write pending is ignored.
    spur_ack = 1'b1;
    cycles(4);
    spur_ack = 1'b0;
    cycles(1);
    check("spur_count", 32'(count), 32'd12);
    check("spur_addr", 32'(imem_addr), 32'd12);

    // finish together with in_valid: finish wins, input not consumed.
`ifdef INSTR_ENC_HALT_EN
    sb.push_back('{addr: exp_addr, data: HALT_WORD});
    exp_count++;
`endif
    @(negedge clk);
    in_kind = KIND_DP_REG; in_alu = ALU_ADD; in_cond = 4'hE;
    in_rd = 4'd1; in_rn = 4'd1; in_rm = 4'd1;
    in_valid = 1'b1;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    in_valid = 1'b0;
    drain();
    cycles(1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(in_ready), 32'd0);
    check("done_count", 32'(count), 32'(exp_count));

    // start and finish together: start wins and clears status.
    @(negedge clk);
    start = 1'b1;
    finish = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish = 1'b0;
    exp_addr = '0;
    exp_count = 0;
    check("restart_ready", 32'(in_ready), 32'd1);
    check("restart_err", 32'(err), 32'd0);
    check("restart_count", 32'(count), 32'd0);
    check("restart_addr", 32'(imem_addr), 32'd0);

    // start during a stalled write aborts it.
    ack_delay = 20;
    send(KIND_LDR, ALU_ADD, 4'hE, 4'd1, 4'd2, 4'd0, 12'h010, '0, 1'b1, 32'hE592_1010);
    cycles(2);
    check("stall_we", 32'(imem_we), 32'd1);
    pulse_start();
    sb.delete();
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_count", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a write drops the strobe at once.
    send(KIND_LDR, ALU_ADD, 4'hE, 4'd1, 4'd2, 4'd0, 12'h010, '0, 1'b1, 32'hE592_1010);
    cycles(1);
    check("stall_we2", 32'(imem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_we", 32'(imem_we), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    ack_delay = 0;

    // Fill the whole address space.
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      logic [3:0] rd, rn, rm;
      rd = 4'(i);
      rn = 4'(i + 1);
      rm = 4'(i + 2);
      send(KIND_DP_REG, ALU_ADD, 4'hE, rd, rn, rm, 12'h000, '0, 1'b1,
           {12'hE08, rn, rd, 8'h00, rm});
    end
    drain();
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_count", 32'(count), 32'd64);
    @(negedge clk);
    in_valid = 1'b1;
    cycles(3);
    in_valid = 1'b0;
    check("full_no_take", 32'(count), 32'd64);

    // finish out of FULL goes straight to DONE with no write.
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    cycles(2);
    check("full_done_full", 32'(full), 32'd0);
    check("full_done_busy", 32'(busy), 32'd0);
    check("full_done_we", 32'(imem_we), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
